// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if: UART rx/tx handshake plus register bus seen by uart_reg_bridge.
interface uart_reg_bridge_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_error;
    modport master (
        input  received, rx_byte, recv_error, is_transmitting, reg_rdata,
        output transmit, tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_error
    );
    modport slave (
        output received, rx_byte, recv_error, is_transmitting, reg_rdata,
        input  transmit, tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_error
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes 'W' addr data / 'R' addr frames from the UART into register bus cycles and a one-byte reply.
module uart_reg_bridge #(
    parameter int         TIMEOUT_CYCLES = 2000000,
    parameter int         TIMEOUT_W      = 21,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15
) (
    input logic               clk,
    input logic               rst,
    uart_reg_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, READ, READ_CAP, REPLY} state_t;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    state_t               r_state, w_next;
    logic                 r_op_wr;
    logic [7:0]           r_addr, r_wdata, r_tx;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_ferr;
    logic                 w_cnt_state, w_rx_state, w_accept, w_timeout, w_abort, w_is_cmd;
    assign w_cnt_state = r_state == GET_ADDR || r_state == GET_DATA;
    assign w_rx_state  = r_state == IDLE || w_cnt_state;
    assign w_accept    = w_rx_state && bus.received && !bus.recv_error;
    // A byte arriving on the last allowed cycle still counts as in time.
    assign w_timeout   = w_cnt_state && !bus.received && r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    assign w_abort     = (w_rx_state && bus.recv_error) || w_timeout;
    assign w_is_cmd    = bus.rx_byte == CMD_W || bus.rx_byte == CMD_R;
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_abort)
            w_next = IDLE;
        else
            case (r_state)
                IDLE:     if (w_accept) w_next = w_is_cmd ? GET_ADDR : REPLY;
                GET_ADDR: if (w_accept) w_next = r_op_wr ? GET_DATA : READ;
                GET_DATA: if (w_accept) w_next = WRITE;
                WRITE:    w_next = REPLY;
                READ:     w_next = READ_CAP;
                READ_CAP: w_next = REPLY;
                REPLY:    if (!bus.is_transmitting) w_next = IDLE;
                default:  w_next = IDLE;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_wr <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_tx    <= 8'h00;
            r_cnt   <= '0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt  <= (w_accept || !w_cnt_state) ? '0 : r_cnt + 1'b1;
            r_ferr <= w_abort;
            if (w_accept && r_state == IDLE) r_op_wr <= bus.rx_byte == CMD_W;
            if (w_accept && r_state == GET_ADDR) r_addr <= bus.rx_byte;
            if (w_accept && r_state == GET_DATA) r_wdata <= bus.rx_byte;
            if (w_accept && r_state == IDLE && !w_is_cmd) r_tx <= NAK_BYTE;
            else if (r_state == WRITE) r_tx <= ACK_BYTE;
            else if (r_state == READ_CAP) r_tx <= bus.reg_rdata;
        end
    end
    always_comb begin
        bus.transmit    = r_state == REPLY && !bus.is_transmitting;
        bus.tx_byte     = r_tx;
        bus.reg_addr    = r_addr;
        bus.reg_wdata   = r_wdata;
        bus.reg_we      = r_state == WRITE;
        bus.reg_re      = r_state == READ;
        bus.busy        = r_state != IDLE;
        bus.frame_error = r_ferr;
    end
endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Host-side command responder for the UART: consumes bytes from the UART's receive handshake, decodes a 2-/3-byte register read/write protocol, drives a simple register bus, and returns a one-byte reply through the UART's transmit handshake. It sits between the UART and the block's control/status registers, giving an external host half-duplex register access over the serial line.

## Interface
- TIMEOUT_CYCLES, 2000000: maximum clk cycles allowed between bytes of one frame (40 ms at 50 MHz).
- TIMEOUT_W, 21: width of the inter-byte timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.
- ACK_BYTE, 8'h06: reply to a completed write.
- NAK_BYTE, 8'h15: reply to an unknown command byte.
- clk  in  1  master clock.
- rst  in  1  reset; synchronous, active-high.
- received  in  1  one-cycle pulse from the UART: rx_byte valid.
- rx_byte  in  8  received byte.
- recv_error  in  1  one-cycle pulse from the UART: framing error.
- is_transmitting  in  1  high while the UART transmitter is busy.
- transmit  out  1  one-cycle request to the UART to send tx_byte.
- tx_byte  out  8  reply byte; stable whenever transmit is high.
- reg_addr  out  8  register bus address.
- reg_wdata  out  8  register bus write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid the cycle after reg_re.
- busy  out  1  high whenever state != IDLE.
- frame_error  out  1  one-cycle pulse: frame aborted (recv_error or timeout).

## Operation
- Protocol: write = 0x57 ('W'), addr, data -> ACK_BYTE. Read = 0x52 ('R'), addr -> register value. Any other first byte -> NAK_BYTE.
- States: IDLE, GET_ADDR, GET_DATA, WRITE, READ, READ_CAP, REPLY.
- IDLE: received with 0x57 or 0x52 -> GET_ADDR (remember op); other byte -> load tx_byte=NAK_BYTE, go to REPLY.
- GET_ADDR: received -> latch reg_addr; op W -> GET_DATA, op R -> READ.
- GET_DATA: received -> latch reg_wdata, go to WRITE.
- WRITE: reg_we=1 for this single cycle; load tx_byte=ACK_BYTE; -> REPLY.
- READ: reg_re=1 for this single cycle; -> READ_CAP.
- READ_CAP: tx_byte <= reg_rdata; -> REPLY.
- REPLY: transmit = (state==REPLY) && !is_transmitting (combinational); in the cycle transmit is high, -> IDLE. If is_transmitting stays high, REPLY holds indefinitely.
- Timeout: counter cleared on entry to GET_ADDR/GET_DATA and on each accepted byte; increments in GET_ADDR/GET_DATA; at TIMEOUT_CYCLES-1 -> IDLE, frame_error pulse, no reply.
- recv_error in IDLE, GET_ADDR or GET_DATA: -> IDLE, frame_error pulse, no reply, partial frame discarded.
- received or recv_error in WRITE, READ, READ_CAP, REPLY: byte dropped, no state effect.
- recv_error and received are never high together; if they are, recv_error wins.
- reg_addr/reg_wdata hold their last latched values between frames.

## Timing
- Reset values: transmit 0, tx_byte 8'h00, reg_addr 8'h00, reg_wdata 8'h00, reg_we 0, reg_re 0, busy 0, frame_error 0; state IDLE, timeout counter 0.
- rst mid-frame or mid-REPLY abandons the frame; no transmit, reg_we or reg_re after rst.
- Let cycle N be the received pulse of the last frame byte.
- Write: reg_we high in N+1; earliest transmit in N+2.
- Read: reg_re high in N+1; reg_rdata sampled at the end of N+2; earliest transmit in N+3.
- NAK: first byte at N -> earliest transmit in N+1.
- reg_we and reg_re are never high in the same cycle; each is high at most once per frame.
- transmit is high for exactly one cycle per reply. is_transmitting rises the following cycle, so there is no double request.
- frame_error is a single-cycle pulse in the cycle after the abort cause.

## Test plan
- Write: send 0x57,0x12,0xA5 with UART idle -> reg_we pulse with addr 0x12/wdata 0xA5 one cycle after the third received, then transmit with tx_byte 0x06 one cycle later.
- Read: send 0x52,0x34, slave returns 0x5C -> reg_re with addr 0x34 at N+1, transmit with tx_byte 0x5C at N+3.
- Unknown/NAK with busy UART: send 0x41 while is_transmitting=1 for 20 cycles -> REPLY holds, transmit is high in the first cycle is_transmitting=0, tx_byte 0x15.
- Abort: send 0x57,0x12, then recv_error -> frame_error pulse, no reg_we, no transmit; the next 0x52,0x12 frame is processed normally.
- Timeout: TIMEOUT_CYCLES=100, send 0x52, then silence -> frame_error after 100 cycles, busy falls, no reg_re.
- Reset mid-REPLY: hold is_transmitting=1 in REPLY, assert rst -> all outputs at reset values next cycle, no transmit when is_transmitting falls.
